// File: rtl/sprite_engine.sv
// Bouncing-sprite game core: N sprites, one player, PLAY/FLASH/OVER lives FSM, registered RGB.
// Define SPRITE_ENGINE_SCORE_EN to enable the frames-survived score counter; otherwise score is 0.
module sprite_engine #(
    parameter int unsigned N_SPRITES    = 4,
    parameter int unsigned SPRITE_SIZE  = 32,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MAX        = 479,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned FLASH_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  player_x,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic [1:0]  lives,
    output logic [7:0]  hit_count,
    output logic        game_over,
    output logic [15:0] score
);
    localparam int unsigned PW    = 11;
    localparam int unsigned FW    = 16;
    localparam int unsigned X_LIM = X_MAX + 1 - SPRITE_SIZE;
    localparam int unsigned Y_LIM = Y_MAX + 1 - SPRITE_SIZE;
    localparam logic [PW-1:0] X_LIM_P = PW'(X_LIM);
    localparam logic [PW-1:0] Y_LIM_P = PW'(Y_LIM);
    localparam logic [PW-1:0] SZ      = PW'(SPRITE_SIZE);
    localparam logic [PW-1:0] SPD     = PW'(SPEED);

    typedef enum logic [1:0] {PLAY = 2'd0, FLASH = 2'd1, OVER = 2'd2} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   sx [N_SPRITES];
    logic [PW-1:0]   sy [N_SPRITES];
    logic            sx_neg [N_SPRITES];
    logic            sy_neg [N_SPRITES];
    logic [9:0]      player_reg;
    logic [FW-1:0]   flash_cnt, flash_next;
    logic [1:0]      lives_next;
    logic [7:0]      hits_next;
    logic            flag;
    logic [11:0]     rgb_next;

    logic            tick_c, advance_c;
    logic [PW-1:0]   x_c, y_c, player_left_c;
    logic            sprite_pix_c, player_pix_c, player_vis_c, hit_now_c;

    function automatic logic [PW-1:0] init_x(input int unsigned i);
        return PW'((i * 2 * SPRITE_SIZE) % X_LIM);
    endfunction

    function automatic logic [PW-1:0] init_y(input int unsigned i);
        return PW'((i * SPRITE_SIZE) % Y_LIM);
    endfunction

    // One axis step with wall bounce; result is {new_negative_direction, new_position}.
    function automatic logic [PW:0] step(input logic [PW-1:0] pos, input logic neg,
                                         input logic [PW-1:0] lim);
        logic [PW-1:0] p;
        logic          n;
        p = pos;
        n = neg;
        if (neg) begin
            if (pos < SPD) begin
                p = '0;
                n = 1'b0;
            end else begin
                p = pos - SPD;
            end
        end else begin
            if (pos + SPD > lim) begin
                p = lim;
                n = 1'b1;
            end else begin
                p = pos + SPD;
            end
        end
        return {n, p};
    endfunction

    assign tick_c        = (y == 10'd481) && (x == 10'd0);
    assign advance_c     = tick_c && !pause && (state != OVER);
    assign x_c           = PW'(x);
    assign y_c           = PW'(y);
    assign player_left_c = (PW'(player_reg) > X_LIM_P) ? X_LIM_P : PW'(player_reg);
    assign player_pix_c  = (x_c >= player_left_c) && (x_c < player_left_c + SZ) &&
                           (y_c >= Y_LIM_P) && (y_c < Y_LIM_P + SZ);
    assign player_vis_c  = !((state == FLASH) && flash_cnt[2]);
    assign hit_now_c     = video_on && player_pix_c && sprite_pix_c;

    always_comb begin
        sprite_pix_c = 1'b0;
        for (int unsigned i = 0; i < N_SPRITES; i++) begin
            if ((x_c >= sx[i]) && (x_c < sx[i] + SZ) && (y_c >= sy[i]) && (y_c < sy[i] + SZ))
                sprite_pix_c = 1'b1;
        end
    end

    // Sprite motion and player sampling, frozen while paused or in OVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                sx[i]     <= init_x(i);
                sy[i]     <= init_y(i);
                sx_neg[i] <= 1'b0;
                sy_neg[i] <= i[0];
            end
            player_reg <= '0;
        end else if (advance_c) begin
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                {sx_neg[i], sx[i]} <= step(sx[i], sx_neg[i], X_LIM_P);
                {sy_neg[i], sy[i]} <= step(sy[i], sy_neg[i], Y_LIM_P);
            end
            player_reg <= player_x;
        end
    end

    // Collision flag: a tick hands over to the next frame, keeping only a same-cycle hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flag <= 1'b0;
        else if (tick_c && !pause)
            flag <= hit_now_c;
        else if (hit_now_c)
            flag <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PLAY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick_c && !pause) begin
            case (state)
                PLAY:    if (flag) state_next = (lives == 2'd1) ? OVER : FLASH;
                FLASH:   if (flash_cnt == FW'(1)) state_next = PLAY;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        lives_next = lives;
        hits_next  = hit_count;
        flash_next = flash_cnt;
        if (tick_c && !pause) begin
            case (state)
                PLAY: begin
                    if (flag) begin
                        lives_next = lives - 2'd1;
                        hits_next  = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
                        flash_next = (lives == 2'd1) ? '0 : FW'(FLASH_FRAMES);
                    end
                end
                FLASH:   flash_next = flash_cnt - FW'(1);
                default: flash_next = flash_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives     <= 2'(LIVES);
            hit_count <= '0;
            flash_cnt <= '0;
            game_over <= 1'b0;
        end else begin
            lives     <= lives_next;
            hit_count <= hits_next;
            flash_cnt <= flash_next;
            game_over <= (state_next == OVER);
        end
    end

    // Pixel colour priority: blanking, player, sprites, background.
    always_comb begin
        rgb_next = 12'h000;
        if (!video_on)
            rgb_next = 12'h000;
        else if (player_pix_c && player_vis_c)
            rgb_next = 12'h0F0;
        else if (sprite_pix_c)
            rgb_next = 12'hF00;
        else if (state == OVER)
            rgb_next = 12'h400;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgb <= 12'h000;
        else
            rgb <= rgb_next;
    end

`ifdef SPRITE_ENGINE_SCORE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score <= '0;
        else if (advance_c && (score != 16'hFFFF))
            score <= score + 16'd1;
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Randomized bench for sprite_engine: pixel probes and frame ticks checked against a
// rectangle-level game model (positions, lives, flash timer, score).
module tb_sprite_engine;
    localparam int NS  = 4;
    localparam int SZ  = 32;
    localparam int SPD = 2;
    localparam int XM  = 639;
    localparam int YM  = 479;
    localparam int NL  = 3;
    localparam int FF  = 30;
    localparam int XL  = XM + 1 - SZ;
    localparam int YL  = YM + 1 - SZ;
`ifdef SPRITE_ENGINE_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    typedef enum int {M_PLAY, M_FLASH, M_OVER} mode_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  x, y, player_x;
    logic        pause;
    logic [11:0] rgb;
    logic [1:0]  lives;
    logic [7:0]  hit_count;
    logic        game_over;
    logic [15:0] score;

    int    checks = 0;
    int    errors = 0;
    int    m_x [NS];
    int    m_y [NS];
    int    m_dx [NS];
    int    m_dy [NS];
    int    m_lives, m_hits, m_score, m_fc, m_preg;
    bit    m_flag;
    mode_t m_mode;

    sprite_engine dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .player_x(player_x), .pause(pause), .rgb(rgb), .lives(lives),
        .hit_count(hit_count), .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_sq(input int px, input int py, input int l, input int t);
        return (px >= l) && (px < l + SZ) && (py >= t) && (py < t + SZ);
    endfunction

    function automatic int pl();
        return (m_preg > XL) ? XL : m_preg;
    endfunction

    function automatic bit any_sprite(input int px, input int py);
        for (int i = 0; i < NS; i++)
            if (in_sq(px, py, m_x[i], m_y[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit collide(input int px, input int py, input bit von);
        return von && in_sq(px, py, pl(), YL) && any_sprite(px, py);
    endfunction

    function automatic logic [11:0] exp_rgb(input int px, input int py, input bit von);
        bit vis;
        vis = !(m_mode == M_FLASH && (m_fc & 4) != 0);
        if (!von) return 12'h000;
        if (vis && in_sq(px, py, pl(), YL)) return 12'h0F0;
        if (any_sprite(px, py)) return 12'hF00;
        return (m_mode == M_OVER) ? 12'h400 : 12'h000;
    endfunction

    function automatic int lowest();
        int b = 0;
        for (int i = 1; i < NS; i++)
            if (m_y[i] > m_y[b]) b = i;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_x[i]  = (i * 2 * SZ) % XL;
            m_y[i]  = (i * SZ) % YL;
            m_dx[i] = SPD;
            m_dy[i] = (i % 2 == 0) ? SPD : -SPD;
        end
        m_lives = NL; m_hits = 0; m_score = 0; m_fc = 0; m_preg = 0;
        m_flag = 1'b0; m_mode = M_PLAY;
    endtask

    task automatic move(inout int p, inout int d, input int lim);
        if (d < 0) begin
            if (p < SPD) begin p = 0; d = -d; end
            else p = p + d;
        end else begin
            if (p + SPD > lim) begin p = lim; d = -d; end
            else p = p + d;
        end
    endtask

    task automatic model_tick(input bit hit_here);
        int p, d;
        if (m_mode != M_OVER) begin
            if (m_score < 16'hFFFF) m_score++;
            for (int i = 0; i < NS; i++) begin
                p = m_x[i]; d = m_dx[i]; move(p, d, XL); m_x[i] = p; m_dx[i] = d;
                p = m_y[i]; d = m_dy[i]; move(p, d, YL); m_y[i] = p; m_dy[i] = d;
            end
            m_preg = int'(player_x);
            if (m_mode == M_PLAY && m_flag) begin
                m_lives--;
                if (m_hits < 255) m_hits++;
                if (m_lives == 0) begin m_mode = M_OVER; m_fc = 0; end
                else begin m_mode = M_FLASH; m_fc = FF; end
            end else if (m_mode == M_FLASH) begin
                m_fc--;
                if (m_fc == 0) m_mode = M_PLAY;
            end
        end
        m_flag = hit_here;
    endtask

    // One clock: drive on the falling edge, check registered outputs on the next one.
    task automatic drive(input int px, input int py, input bit von);
        logic [11:0] e;
        bit c, tk;
        x = 10'(px); y = 10'(py); video_on = von;
        e  = exp_rgb(px, py, von);
        c  = collide(px, py, von);
        tk = (px == 0) && (py == 481);
        @(negedge clk);
        if (tk && !pause) model_tick(c);
        else if (c) m_flag = 1'b1;
        chk("rgb", rgb, e);
        if (tk) begin
            chk("lives", lives, m_lives);
            chk("hit_count", hit_count, m_hits);
            chk("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
            chk("score", score, SCORE_EN ? m_score : 0);
        end
    endtask

    task automatic frame(input int nprobe, input bit allow_hit, input bit seek_hit);
        int px, py, j, ix0, iy0;
        bit von, done;
        done = 1'b0;
        if (seek_hit) begin
            for (int i = 0; i < NS; i++) begin
                ix0 = (m_x[i] > pl()) ? m_x[i] : pl();
                iy0 = (m_y[i] > YL) ? m_y[i] : YL;
                if (!done && in_sq(ix0, iy0, m_x[i], m_y[i]) && in_sq(ix0, iy0, pl(), YL)) begin
                    drive(ix0, iy0, 1'b1);
                    done = 1'b1;
                end
            end
        end
        for (int k = 0; k < nprobe; k++) begin
            j   = $urandom_range(0, NS - 1);
            von = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 4))
                0: begin px = $urandom_range(0, XM); py = $urandom_range(0, YM); end
                1: begin px = m_x[j]; py = m_y[j]; end
                2: begin
                    px = (m_x[j] == 0) ? m_x[j] + SZ : m_x[j] - 1;
                    py = m_y[j] + $urandom_range(0, SZ - 1);
                end
                3: begin px = m_x[j] + SZ - 1; py = m_y[j] + SZ - 1; end
                default: begin
                    px = pl() + $urandom_range(0, SZ - 1);
                    py = YL + $urandom_range(0, SZ - 1);
                end
            endcase
            if (!allow_hit && collide(px, py, von)) von = 1'b0;
            drive(px, py, von);
        end
        drive(0, 481, 1'b0);
    endtask

    initial begin
        bit first_seen, bg_done;
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0; player_x = '0; pause = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_lives", lives, NL);
        chk("rst_hits", hit_count, 0);
        chk("rst_over", game_over, 0);
        chk("rst_score", score, 0);
        chk("rst_rgb", rgb, 12'h000);
        reset = 1'b0;

        // Hit-free play: motion, bounces and score accumulate.
        for (int f = 0; f < 100; f++) frame(5, 1'b0, 1'b0);
        chk("score_100", score, SCORE_EN ? 100 : 0);
        chk("lives_nohit", lives, NL);

        // Pause: nothing advances and player_x is ignored.
        pause = 1'b1;
        for (int f = 0; f < 20; f++) begin
            player_x = 10'($urandom_range(0, 1023));
            frame(4, 1'b0, 1'b0);
        end
        chk("pause_score", score, SCORE_EN ? 100 : 0);
        chk("pause_lives", lives, NL);
        pause = 1'b0;
        player_x = '0;
        for (int f = 0; f < 10; f++) frame(4, 1'b0, 1'b0);
        chk("resume_score", score, SCORE_EN ? 110 : 0);

        // Chase the lowest sprite with the player until the game ends.
        first_seen = 1'b0;
        for (int f = 0; f < 3000 && m_mode != M_OVER; f++) begin
            player_x = 10'(m_x[lowest()]);
            frame(3, 1'b1, 1'b1);
            if (!first_seen && m_hits == 1) begin
                first_seen = 1'b1;
                chk("hit1_lives", lives, NL - 1);
                chk("hit1_count", hit_count, 1);
            end
        end
        chk("over_reached", game_over, 1);
        chk("over_lives", lives, 0);
        chk("over_hits", hit_count, NL);
        for (int f = 0; f < 10; f++) frame(5, 1'b1, 1'b1);
        bg_done = 1'b0;
        for (int py = 0; py <= YM && !bg_done; py += 16) begin
            if (!any_sprite(XM, py) && !in_sq(XM, py, pl(), YL)) begin
                drive(XM, py, 1'b1);
                chk("over_bg", rgb, 12'h400);
                bg_done = 1'b1;
            end
        end
        chk("over_hold", game_over, 1);

        // Fresh game, take one hit, then reset while the flash counter is at 12.
        x = '0; y = '0; video_on = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        for (int f = 0; f < 3000 && !(m_mode == M_FLASH && m_fc == 12); f++) begin
            player_x = 10'(m_x[lowest()]);
            frame(2, m_mode == M_PLAY, m_mode == M_PLAY);
        end
        chk("flash12_lives", lives, NL - 1);
        drive(pl() + 1, YL + 1, 1'b1);
        chk("flash12_blink", rgb, 12'h000);
        #2 reset = 1'b1;
        x = '0; y = '0; video_on = 1'b0;
        #1;
        chk("midrst_lives", lives, NL);
        chk("midrst_hits", hit_count, 0);
        chk("midrst_over", game_over, 0);
        chk("midrst_rgb", rgb, 12'h000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        player_x = '0;
        drive(pl() + 1, YL + 1, 1'b1);
        chk("postrst_player", rgb, 12'h0F0);
        for (int f = 0; f < 20; f++) frame(4, 1'b0, 1'b0);
        chk("postrst_lives", lives, NL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
